uart_tx_arb: RTL

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// A packet (bytes up to req_last) holds the transmitter; a missing busy response raises a sticky err.
module uart_tx_arb #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_wr_en,
    output logic [7:0]           tx_byte,
    input  logic                 tx_busy,
    output logic                 arb_busy,
    output logic                 err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TIM_W = 8;

    if ((N_REQ < 2) || (N_REQ > 8)) begin : g_bad_n_req
        $error("uart_tx_arb: N_REQ must be in 2..8");
    end
    if ((BUSY_TIMEOUT < 0) || (BUSY_TIMEOUT > (2**TIM_W) - 1)) begin : g_bad_timeout
        $error("uart_tx_arb: BUSY_TIMEOUT does not fit the timeout counter");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        LOCK      = 2'd3
    } state_t;

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx   = (int'(ptr) + k) % N_REQ;
            pick  = (!found && valid[idx]) ? IDX_W'(idx) : pick;
            found = found | valid[idx];
        end
        return pick;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (int'(idx) == (N_REQ - 1)) ? {IDX_W{1'b0}} : (idx + IDX_W'(1));
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IDX_W-1:0]   owner_r, owner_s;
    logic [N_REQ-1:0]   grant_r, grant_s;
    logic [N_REQ-1:0]   req_ready_r, req_ready_s;
    logic               tx_wr_en_r, tx_wr_en_s;
    logic [7:0]         tx_byte_r, tx_byte_s;
    logic               arb_busy_r, arb_busy_s;
    logic               err_r, err_s;
    logic               last_q_r, last_q_s;
    logic [TIM_W-1:0]   tim_r, tim_s;
    logic               accept_s;
    logic [IDX_W-1:0]   acc_idx_s;

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        owner_s     = owner_r;
        grant_s     = grant_r;
        req_ready_s = {N_REQ{1'b0}};
        tx_wr_en_s  = 1'b0;
        tx_byte_s   = tx_byte_r;
        err_s       = err_r;
        last_q_s    = last_q_r;
        tim_s       = tim_r;
        accept_s    = 1'b0;
        acc_idx_s   = rr_pick(req_valid, rr_ptr_r);

        case (state_r)
            IDLE: begin
                if (!tx_busy && (|req_valid)) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            WAIT_BUSY: begin
                tim_s = tim_r + TIM_W'(1);
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else if (tim_r == TIM_W'(BUSY_TIMEOUT)) begin
                    err_s   = 1'b1;
                    grant_s = {N_REQ{1'b0}};
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else if (last_q_r) begin
                    grant_s  = {N_REQ{1'b0}};
                    rr_ptr_s = rr_next(owner_r);
                    state_s  = IDLE;
                end else begin
                    state_s = LOCK;
                end
            end
            LOCK: begin
                // Mid-packet only the owner is looked at; everyone else waits.
                acc_idx_s = owner_r;
                if (!tx_busy && req_valid[owner_r]) begin
                    accept_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {N_REQ{1'b0}};
            end
        endcase

        if (accept_s) begin
            tx_wr_en_s  = 1'b1;
            tx_byte_s   = req_data[{acc_idx_s, 3'b000} +: 8];
            req_ready_s = onehot(acc_idx_s);
            grant_s     = onehot(acc_idx_s);
            last_q_s    = req_last[acc_idx_s];
            owner_s     = acc_idx_s;
            tim_s       = {TIM_W{1'b0}};
            state_s     = WAIT_BUSY;
        end else begin
            tx_wr_en_s  = 1'b0;
        end

        arb_busy_s = (state_s != IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {IDX_W{1'b0}};
            owner_r     <= {IDX_W{1'b0}};
            grant_r     <= {N_REQ{1'b0}};
            req_ready_r <= {N_REQ{1'b0}};
            tx_wr_en_r  <= 1'b0;
            tx_byte_r   <= 8'h00;
            arb_busy_r  <= 1'b0;
            err_r       <= 1'b0;
            last_q_r    <= 1'b0;
            tim_r       <= {TIM_W{1'b0}};
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            owner_r     <= owner_s;
            grant_r     <= grant_s;
            req_ready_r <= req_ready_s;
            tx_wr_en_r  <= tx_wr_en_s;
            tx_byte_r   <= tx_byte_s;
            arb_busy_r  <= arb_busy_s;
            err_r       <= err_s;
            last_q_r    <= last_q_s;
            tim_r       <= tim_s;
        end
    end

    assign req_ready = req_ready_r;
    assign grant     = grant_r;
    assign tx_wr_en  = tx_wr_en_r;
    assign tx_byte   = tx_byte_r;
    assign arb_busy  = arb_busy_r;
    assign err       = err_r;

endmodule
